// File: rtl/lcd1602_row_writer_if.sv
// Write-only 8-bit parallel bus between the row writer and an HD44780-style 1602 LCD.
interface lcd1602_row_writer_if;
  logic       lcd_en;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_data;

  modport master (output lcd_en, output lcd_rs, output lcd_rw, output lcd_data);
  modport slave  (input  lcd_en, input  lcd_rs, input  lcd_rw, input  lcd_data);
endinterface

// File: rtl/lcd1602_row_writer.sv
// Power-on init plus change-driven full-frame rewrite of two 16-char rows to a 1602 LCD.
// Optional macro LCD_BLANK_NONPRINT_EN: non-printable data bytes are shown as spaces.
module lcd1602_row_writer #(
  parameter int POR_CYC    = 20,
  parameter int PERIOD_CYC = 8,
  parameter int PULSE_CYC  = 3,
  parameter int CLEAR_CYC  = 40
) (
  input  logic                        clk,
  input  logic                        nRst,
  input  logic [127:0]                row_top,
  input  logic [127:0]                row_bot,
  lcd1602_row_writer_if.master        lcd,
  output logic                        busy
);

  localparam logic [1:0] ST_POR   = 2'd0;
  localparam logic [1:0] ST_INIT  = 2'd1;
  localparam logic [1:0] ST_FRAME = 2'd2;
  localparam logic [1:0] ST_IDLE  = 2'd3;
  localparam int CW = 16;

`ifdef LCD_BLANK_NONPRINT_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic [1:0]    state_r, state_nxt_s;
  logic [5:0]    step_r, step_nxt_s;
  logic [CW-1:0] off_r, off_nxt_s, last_off_s;
  logic [127:0]  snap_top_r, snap_bot_r;
  logic [8:0]    cur_s, nxt_s;
  logic          xfer_s, en_nxt_s;

  function automatic logic [7:0] pick_char(input logic [127:0] row, input logic [3:0] idx);
    logic [127:0] sh;
    sh = row << {idx, 3'b000};
    return sh[127:120];
  endfunction

  function automatic logic [7:0] out_byte(input logic rs, input logic [7:0] b);
    if (BLANK_EN && rs && ((b < 8'h20) || (b > 8'h7E))) begin
      return 8'h20;
    end else begin
      return b;
    end
  endfunction

  // {rs, byte} of the transfer selected by a state/step pair
  function automatic logic [8:0] xfer_sel(input logic [1:0] st, input logic [5:0] stp,
                                          input logic [127:0] top, input logic [127:0] bot);
    logic [8:0] r;
    r = 9'h000;
    case (st)
      ST_INIT: begin
        case (stp)
          6'd0:    r = {1'b0, 8'h38};
          6'd1:    r = {1'b0, 8'h0C};
          6'd2:    r = {1'b0, 8'h01};
          6'd3:    r = {1'b0, 8'h06};
          default: r = 9'h000;
        endcase
      end
      ST_FRAME: begin
        if (stp == 6'd0) begin
          r = {1'b0, 8'h80};
        end else if (stp <= 6'd16) begin
          r = {1'b1, pick_char(top, 4'(stp - 6'd1))};
        end else if (stp == 6'd17) begin
          r = {1'b0, 8'hC0};
        end else begin
          r = {1'b1, pick_char(bot, 4'(stp - 6'd18))};
        end
      end
      default: r = 9'h000;
    endcase
    return r;
  endfunction

  assign cur_s      = xfer_sel(state_r, step_r, snap_top_r, snap_bot_r);
  assign last_off_s = (cur_s == {1'b0, 8'h01}) ? CW'(CLEAR_CYC - 1) : CW'(PERIOD_CYC - 1);

  // Sequencer next state: POR delay, init commands, 34-step frame, idle compare
  always_comb begin
    state_nxt_s = state_r;
    step_nxt_s  = step_r;
    off_nxt_s   = off_r;
    case (state_r)
      ST_POR: begin
        if (off_r == CW'(POR_CYC - 1)) begin
          state_nxt_s = ST_INIT;
          step_nxt_s  = 6'd0;
          off_nxt_s   = '0;
        end else begin
          off_nxt_s = off_r + CW'(1);
        end
      end
      ST_INIT: begin
        if (off_r == last_off_s) begin
          off_nxt_s = '0;
          if (step_r == 6'd3) begin
            state_nxt_s = ST_FRAME;
            step_nxt_s  = 6'd0;
          end else begin
            step_nxt_s = step_r + 6'd1;
          end
        end else begin
          off_nxt_s = off_r + CW'(1);
        end
      end
      ST_FRAME: begin
        if (off_r == last_off_s) begin
          off_nxt_s = '0;
          if (step_r == 6'd33) begin
            state_nxt_s = ST_IDLE;
            step_nxt_s  = 6'd0;
          end else begin
            step_nxt_s = step_r + 6'd1;
          end
        end else begin
          off_nxt_s = off_r + CW'(1);
        end
      end
      ST_IDLE: begin
        if ({row_top, row_bot} != {snap_top_r, snap_bot_r}) begin
          state_nxt_s = ST_FRAME;
          step_nxt_s  = 6'd0;
          off_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_POR;
        step_nxt_s  = 6'd0;
        off_nxt_s   = '0;
      end
    endcase
  end

  // Outputs are registered from the next-cycle position so they align with the state
  assign nxt_s    = xfer_sel(state_nxt_s, step_nxt_s, snap_top_r, snap_bot_r);
  assign xfer_s   = (state_nxt_s == ST_INIT) || (state_nxt_s == ST_FRAME);
  assign en_nxt_s = xfer_s && (off_nxt_s >= CW'(1)) && (off_nxt_s <= CW'(PULSE_CYC));

  assign lcd.lcd_rw = 1'b0;

  // State, snapshot and registered LCD bus
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_r      <= ST_POR;
      step_r       <= 6'd0;
      off_r        <= '0;
      snap_top_r   <= 128'd0;
      snap_bot_r   <= 128'd0;
      lcd.lcd_en   <= 1'b0;
      lcd.lcd_rs   <= 1'b0;
      lcd.lcd_data <= 8'h00;
      busy         <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      step_r  <= step_nxt_s;
      off_r   <= off_nxt_s;
      // Rows are frozen on the first cycle of a frame so a frame is never torn
      if ((state_r == ST_FRAME) && (step_r == 6'd0) && (off_r == '0)) begin
        snap_top_r <= row_top;
        snap_bot_r <= row_bot;
      end
      lcd.lcd_en <= en_nxt_s;
      if (xfer_s) begin
        lcd.lcd_rs   <= nxt_s[8];
        lcd.lcd_data <= out_byte(nxt_s[8], nxt_s[7:0]);
      end
      busy <= (state_nxt_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_lcd1602_row_writer.sv
// Self-checking bench: monitors LCD strobes and compares against a transfer-list model.
module tb_lcd1602_row_writer;
  localparam int POR = 20, PER = 8, PUL = 3, CLR = 40;

  logic         tb_clk = 1'b0;
  logic         nRst = 1'b0;
  logic [127:0] row_top = 128'd0, row_bot = 128'd0;
  logic         busy;

  lcd1602_row_writer_if lcd_bus();

  lcd1602_row_writer #(.POR_CYC(POR), .PERIOD_CYC(PER), .PULSE_CYC(PUL), .CLEAR_CYC(CLR)) dut (
    .clk(tb_clk), .nRst(nRst), .row_top(row_top), .row_bot(row_bot), .lcd(lcd_bus), .busy(busy));

  always #5 tb_clk = ~tb_clk;

  // cycle index relative to the last reset edge
  int cyc = 0;
  always @(posedge tb_clk) begin
    if (!nRst) cyc <= 0;
    else cyc <= cyc + 1;
  end

  typedef struct { int c; logic rs; logic [7:0] d; } rise_t;
  rise_t      rises[$];
  int         pulse_err = 0, rw_err = 0, busy_fall = -1, width = 0;
  logic       prev_en = 1'b0, prev_busy = 1'b0;
  logic [8:0] held = 9'h000;

  always @(negedge tb_clk) begin
    if (lcd_bus.lcd_rw !== 1'b0) rw_err++;
    if (lcd_bus.lcd_en === 1'b1) begin
      if (prev_en !== 1'b1) begin
        rises.push_back('{cyc, lcd_bus.lcd_rs, lcd_bus.lcd_data});
        held  = {lcd_bus.lcd_rs, lcd_bus.lcd_data};
        width = 0;
      end else if ({lcd_bus.lcd_rs, lcd_bus.lcd_data} !== held) begin
        pulse_err++;
      end
      width++;
    end else if (prev_en === 1'b1 && width != PUL) begin
      pulse_err++;
    end
    if (prev_busy === 1'b1 && busy === 1'b0) busy_fall = cyc;
    prev_en   = lcd_bus.lcd_en;
    prev_busy = busy;
  end

  int tests = 0, fails = 0;

  // reference model: ordered list of {rs,byte} with expected en-rise cycle
  logic [8:0] exp_q[$];
  int         exp_c[$];
  int         mt;

  function automatic logic [7:0] shown(input logic [7:0] b);
`ifdef LCD_BLANK_NONPRINT_EN
    return (b < 8'h20 || b > 8'h7E) ? 8'h20 : b;
`else
    return b;
`endif
  endfunction

  task automatic model_start(input int t);
    exp_q.delete(); exp_c.delete(); mt = t;
  endtask

  task automatic model_push(input logic [8:0] e);
    exp_q.push_back(e);
    exp_c.push_back(mt + 1);
    mt += (e == 9'h001) ? CLR : PER;
  endtask

  task automatic model_init();
    model_push(9'h038); model_push(9'h00C); model_push(9'h001); model_push(9'h006);
  endtask

  task automatic model_frame(input logic [127:0] top, input logic [127:0] bot);
    model_push(9'h080);
    for (int i = 0; i < 16; i++) model_push({1'b1, shown(top[127-8*i -: 8])});
    model_push(9'h0C0);
    for (int i = 0; i < 16; i++) model_push({1'b1, shown(bot[127-8*i -: 8])});
  endtask

  task automatic tick();
    @(negedge tb_clk); #1;
  endtask

  task automatic wait_for(input int need, input bit idle, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (rises.size() >= need && (!idle || busy === 1'b0)) begin ok = 1'b1; break; end
    end
  endtask

  function automatic logic [127:0] rnd_row();
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic test_reset();
    nRst = 1'b0; row_top = "HELLO WORLD     "; row_bot = "GUESS:          ";
    repeat (3) tick();
    tests++; if (lcd_bus.lcd_en !== 1'b0) begin fails++; $display("FAIL reset_en: got %b want 0", lcd_bus.lcd_en); end
    tests++; if (lcd_bus.lcd_rs !== 1'b0) begin fails++; $display("FAIL reset_rs: got %b want 0", lcd_bus.lcd_rs); end
    tests++; if (lcd_bus.lcd_rw !== 1'b0) begin fails++; $display("FAIL reset_rw: got %b want 0", lcd_bus.lcd_rw); end
    tests++; if (lcd_bus.lcd_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %02h want 00", lcd_bus.lcd_data); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b want 1", busy); end
  endtask

  task automatic test_init_frame();
    bit ok;
    rises.delete(); busy_fall = -1;
    model_start(POR); model_init(); model_frame(row_top, row_bot);
    nRst = 1'b1;
    wait_for(38, 1'b1, 2000, ok);
    tests++; if (!ok) begin fails++; $display("FAIL init_timeout: got %0d rises want 38", rises.size()); end
    tests++; if (rises.size() != 38) begin fails++; $display("FAIL init_count: got %0d want 38", rises.size()); end
    for (int i = 0; i < exp_q.size() && i < rises.size(); i++) begin
      tests++;
      if ({rises[i].rs, rises[i].d} !== exp_q[i] || rises[i].c != exp_c[i]) begin
        fails++; $display("FAIL init_seq[%0d]: got %b/%02h@%0d want %03h@%0d", i, rises[i].rs, rises[i].d, rises[i].c, exp_q[i], exp_c[i]);
      end
    end
    tests++; if (rises.size() > 0 && rises[0].c != 21) begin fails++; $display("FAIL first_rise: got %0d want 21", rises[0].c); end
    tests++; if (busy_fall != 356) begin fails++; $display("FAIL busy_fall: got %0d want 356", busy_fall); end
  endtask

  task automatic test_idle_quiet();
    bit hi = 1'b0;
    rises.delete();
    repeat (500) begin tick(); if (busy !== 1'b0) hi = 1'b1; end
    tests++; if (rises.size() != 0) begin fails++; $display("FAIL idle_pulses: got %0d want 0", rises.size()); end
    tests++; if (hi) begin fails++; $display("FAIL idle_busy: got 1 want 0"); end
  endtask

  task automatic test_row_change();
    bit ok; int c;
    for (int it = 0; it < 4; it++) begin
      rises.delete();
      c = cyc;
      if (it == 0) row_bot[127-8*5 -: 8] = 8'h4F;
      else begin row_top = rnd_row(); row_bot = rnd_row(); end
      model_start(c + 1); model_frame(row_top, row_bot);
      wait_for(34, 1'b1, 1000, ok);
      tests++; if (!ok || rises.size() != 34) begin fails++; $display("FAIL change%0d_count: got %0d want 34", it, rises.size()); end
      for (int i = 0; i < exp_q.size() && i < rises.size(); i++) begin
        tests++;
        if ({rises[i].rs, rises[i].d} !== exp_q[i] || rises[i].c != exp_c[i]) begin
          fails++; $display("FAIL change%0d_seq[%0d]: got %b/%02h@%0d want %03h@%0d", it, i, rises[i].rs, rises[i].d, rises[i].c, exp_q[i], exp_c[i]);
        end
      end
      if (it == 0 && rises.size() > 23) begin
        tests++; if (rises[23].d !== 8'h4F || rises[23].rs !== 1'b1) begin fails++; $display("FAIL idx23: got %b/%02h want 1/4f", rises[23].rs, rises[23].d); end
      end
    end
  endtask

  task automatic test_mid_frame_change();
    bit ok; int c; logic [127:0] old_top;
    rises.delete();
    c = cyc; row_bot = rnd_row(); old_top = row_top;
    wait_for(11, 1'b0, 500, ok);
    row_top = rnd_row();
    model_start(c + 1); model_frame(old_top, row_bot); mt += 1; model_frame(row_top, row_bot);
    wait_for(68, 1'b1, 2000, ok);
    tests++; if (!ok || rises.size() != 68) begin fails++; $display("FAIL mid_count: got %0d want 68", rises.size()); end
    for (int i = 0; i < exp_q.size() && i < rises.size(); i++) begin
      tests++;
      if ({rises[i].rs, rises[i].d} !== exp_q[i] || rises[i].c != exp_c[i]) begin
        fails++; $display("FAIL mid_seq[%0d]: got %b/%02h@%0d want %03h@%0d", i, rises[i].rs, rises[i].d, rises[i].c, exp_q[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    rises.delete();
    row_top = rnd_row();
    wait_for(21, 1'b0, 500, ok);
    tests++; if (!ok || lcd_bus.lcd_en !== 1'b1) begin fails++; $display("FAIL rmid_pre_en: got %b want 1", lcd_bus.lcd_en); end
    tests++; if (pulse_err != 0) begin fails++; $display("FAIL pulse_shape: got %0d errors want 0", pulse_err); end
    nRst = 1'b0;
    tick();
    tests++; if (lcd_bus.lcd_en !== 1'b0) begin fails++; $display("FAIL rmid_en: got %b want 0", lcd_bus.lcd_en); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rmid_busy: got %b want 1", busy); end
    nRst = 1'b1; pulse_err = 0; rises.delete();
    model_start(POR); model_init(); model_frame(row_top, row_bot);
    wait_for(38, 1'b1, 2000, ok);
    tests++; if (!ok || rises.size() != 38) begin fails++; $display("FAIL rmid_count: got %0d want 38", rises.size()); end
    for (int i = 0; i < exp_q.size() && i < rises.size(); i++) begin
      tests++;
      if ({rises[i].rs, rises[i].d} !== exp_q[i] || rises[i].c != exp_c[i]) begin
        fails++; $display("FAIL rmid_seq[%0d]: got %b/%02h@%0d want %03h@%0d", i, rises[i].rs, rises[i].d, rises[i].c, exp_q[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_zero_rows();
    bit ok; int bad = 0; logic [7:0] want;
    want = shown(8'h00);
    rises.delete();
    row_top = 128'd0; row_bot = 128'd0;
    wait_for(34, 1'b1, 1000, ok);
    tests++; if (!ok || rises.size() != 34) begin fails++; $display("FAIL zero_count: got %0d want 34", rises.size()); end
    for (int i = 0; i < rises.size(); i++) if (rises[i].rs === 1'b1 && rises[i].d !== want) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL zero_data: got %0d wrong bytes want 0 (byte %02h)", bad, want); end
  endtask

  task automatic test_bus_integrity();
    tests++; if (pulse_err != 0) begin fails++; $display("FAIL pulse_shape_end: got %0d errors want 0", pulse_err); end
    tests++; if (rw_err != 0) begin fails++; $display("FAIL rw_low: got %0d errors want 0", rw_err); end
  endtask

  initial begin
    test_reset();
    test_init_frame();
    test_idle_quiet();
    test_row_change();
    test_mid_frame_change();
    test_reset_mid();
    test_zero_rows();
    test_bus_integrity();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
